im_port_arbiter: RTL
====================

# im_port_arbiter

Shares the single synchronous instruction-memory port between the fetch unit and the program loader/debug port. Each cycle it grants at most one requester, drives the memory port from the winner, and routes the one-cycle-latency read data back to the owner. The loader normally wins, and a starvation guard guarantees fetch progress. In lock mode the loader owns the memory exclusively.

## Interface
Parameters:
- AW, 10: word-address width (byte address bits [11:2]).
- DW, 32: data width.
- STARVE_LIMIT, 4: consecutive loader grants with fetch pending before fetch is forced through; legal 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held stable until granted.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data; 0 when if_rvalid=0.
- ld_req  in  1  loader request; held stable until granted.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  AW  loader word address.
- ld_wdata  in  DW  loader write data.
- ld_lock  in  1  load mode: fetch is never granted.
- ld_gnt  out  1  loader granted this cycle (combinational).
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  DW  loader read data; 0 when ld_rvalid=0.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory word address; 0 when mem_en=0.
- mem_wdata  out  DW  memory write data; 0 unless a loader write is granted.
- mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_en=1, mem_we=0.

## Operation
- Arbitration, evaluated combinationally each cycle:
  - If ld_lock=1: only the loader may win.
  - Else, if if_req=1 and starve_cnt==STARVE_LIMIT: fetch wins.
  - Else, if ld_req=1: the loader wins.
  - Else, if if_req=1: fetch wins.
- if_gnt and ld_gnt are one-hot or both 0. mem_en = if_gnt | ld_gnt. mem_we = ld_gnt & ld_we.
- starve_cnt (4-bit) updates on each rising edge:
  - Increments, saturating at STARVE_LIMIT, when ld_gnt=1 and if_req=1 and ld_lock=0.
  - Clears when if_gnt=1, if_req=0, or ld_lock=1.
  - Holds otherwise.
- Response pipeline:
  - Registered resp_valid/resp_owner capture (mem_en & ~mem_we, winner) each edge.
  - In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata.
  - The non-owner's rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. Responses return in grant order with no gaps.

## Timing
- Grant latency: 0 cycles (same cycle as request when it wins). Read latency: rvalid exactly 1 cycle after grant.
- Reset (asynchronous assert): starve_cnt=0 and resp_valid=0 immediately. While rst=1, all outputs are 0, including if_gnt, ld_gnt and mem_en.
- Reset during an outstanding read: the response is dropped, and no rvalid appears after deassert.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: the loader wins, and fetch stays pending.
- ld_lock rising while fetch is pending: fetch is held off indefinitely. A fetch read already in flight still completes its rvalid.
- ld_lock toggling does not disturb an in-flight response.
- A request that deasserts before grant is a protocol violation; the block is not required to detect it.

## Structure
- Package im_arb_pkg:
  - owner_t enum {OWN_IF, OWN_LD}.
  - STARVE_W=4.
  - Default AW/DW constants shared with the memory and fetch blocks.
- One natural sub-module, im_arb_starve_ctr: the saturating counter, with inputs inc, clr, limit and outputs cnt, at_limit.
- Top level holds the combinational arbiter, memory-port muxing and the response register.

## Test plan
- Fetch only: if_req=1, if_addr=0..5 over consecutive cycles, memory preloaded with word i = i+100.
  - Required: if_gnt every cycle; if_rvalid one cycle later with if_rdata 100..105 in order.
- Loader write then fetch read: ld write addr 3, data 0xDEADBEEF; next cycle fetch addr 3.
  - Required: mem_we=1 only in the first cycle; if_rdata=0xDEADBEEF; ld_rvalid never asserts.
- Contention, STARVE_LIMIT=4: ld_req and if_req held high.
  - Required grant pattern: L,L,L,L,F,L,L,L,L,F; starve_cnt returns to 0 after each F.
- Lock mode: ld_lock=1, both requesting for 20 cycles.
  - Required: if_gnt=0 throughout and starve_cnt=0.
  - After ld_lock drops: fetch granted on the first cycle with ld_req=0 or after 4 loader grants.
- Reset mid-read: fetch read granted, then rst asserted in the following cycle before the clock edge.
  - Required: if_rvalid=0 immediately; all outputs 0 while rst=1; no rvalid after deassert.
- Interleaved reads: alternating loader/fetch reads via lock toggling.
  - Required: each rvalid lands on the correct owner; the other port's rdata stays 0.

Source files
------------

// File: rtl/im_port_arbiter_pkg.sv
// rtl/im_port_arbiter_pkg.sv - shared types and widths for the instruction-memory port arbiter
package im_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LD = 1'b1
  } owner_t;

  localparam int STARVE_W = 4;
  localparam int IM_AW    = 10;
  localparam int IM_DW    = 32;

endpackage

// File: rtl/im_port_arbiter_if.sv
// rtl/im_port_arbiter_if.sv - fetch, loader and memory-port signal bundle
interface im_port_arbiter_if #(
  parameter int AW = im_arb_pkg::IM_AW,
  parameter int DW = im_arb_pkg::IM_DW
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_lock;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side: takes requests and memory read data, drives grants, responses and the port.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory side.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/im_port_arbiter_starve_ctr.sv
// rtl/im_port_arbiter_starve_ctr.sv - saturating count of loader grants taken while fetch waits
module im_arb_starve_ctr
  import im_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  input  logic [STARVE_W-1:0] limit,
  output logic [STARVE_W-1:0] cnt,
  output logic                at_limit
);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - shares the instruction-memory port between fetch and loader
module im_port_arbiter
  import im_arb_pkg::*;
#(
  parameter int AW           = IM_AW,
  parameter int DW           = IM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  im_port_arbiter_if.slave bus
);

  logic                if_win;
  logic                ld_win;
  logic                at_limit;
  logic                starve_inc;
  logic                starve_clr;
  logic [STARVE_W-1:0] starve_cnt;
  logic [AW-1:0]       mem_addr_c;
  logic [DW-1:0]       mem_wdata_c;
  logic                resp_valid_q;
  logic                resp_valid_d;
  owner_t              resp_owner_q;
  owner_t              resp_owner_d;

  // Loader has priority unless fetch has waited STARVE_LIMIT grants; lock shuts fetch out; reset grants nothing.
  always_comb begin
    if_win = 1'b0;
    ld_win = 1'b0;
    if (!rst) begin
      if (bus.ld_lock) begin
        ld_win = bus.ld_req;
      end else if (bus.if_req && at_limit) begin
        if_win = 1'b1;
      end else if (bus.ld_req) begin
        ld_win = 1'b1;
      end else begin
        if_win = bus.if_req;
      end
    end
  end

  // Memory port follows the winner; address and write data are zero when unused.
  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (ld_win) begin
      mem_addr_c = bus.ld_addr;
      if (bus.ld_we) begin
        mem_wdata_c = bus.ld_wdata;
      end
    end else if (if_win) begin
      mem_addr_c = bus.if_addr;
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.ld_gnt    = ld_win;
  assign bus.mem_en    = if_win | ld_win;
  assign bus.mem_we    = ld_win & bus.ld_we;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  assign starve_inc = ld_win & bus.if_req & ~bus.ld_lock;
  assign starve_clr = if_win | ~bus.if_req | bus.ld_lock;

  im_arb_starve_ctr u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .limit    (STARVE_W'(STARVE_LIMIT)),
    .cnt      (starve_cnt),
    .at_limit (at_limit)
  );

  // Remember which requester issued a read so next cycle's memory data goes back to it.
  always_comb begin
    resp_valid_d = (if_win | ld_win) & ~(ld_win & bus.ld_we);
    resp_owner_d = ld_win ? OWN_LD : OWN_IF;
  end

  // Response register; an async reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_IF;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign bus.if_rvalid = resp_valid_q & (resp_owner_q == OWN_IF);
  assign bus.ld_rvalid = resp_valid_q & (resp_owner_q == OWN_LD);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ld_rdata  = bus.ld_rvalid ? bus.mem_rdata : '0;

endmodule
